// File: rtl/operand_addr_seq_pkg.sv
// Shared types for the operand-buffer read-address sequencer: precision encoding,
// FSM state encoding and the precision-to-repeat-count helper.
package operand_addr_seq_pkg;

  typedef enum logic [1:0] {
    PREC_FP32 = 2'd0,
    PREC_FP16 = 2'd1,
    PREC_INT8 = 2'd2,
    PREC_INT4 = 2'd3
  } prec_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aseq_state_e;

  // Number of sub-word lanes packed into one operand word.
  function automatic logic [3:0] rep_of(prec_e p);
    case (p)
      PREC_FP32: return 4'd1;
      PREC_FP16: return 4'd2;
      PREC_INT8: return 4'd4;
      default:   return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/operand_addr_seq_if.sv
// Beat interface between the address sequencer and the operand SRAM read port.
interface operand_addr_seq_if #(
  parameter int ADDR_W = 4,
  parameter int NUM_CH = 2
);
  // A beat (rdaddr, sub_idx, last) transfers on a clock edge where addr_valid and
  // addr_ready are both high; while addr_valid is high and addr_ready is low the
  // master holds every beat field stable, and it never drops addr_valid mid-beat.
  logic                     addr_valid;
  logic                     addr_ready;
  logic [NUM_CH*ADDR_W-1:0] rdaddr;
  logic [2:0]               sub_idx;
  logic                     last;

  modport master (
    output addr_valid, rdaddr, sub_idx, last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, rdaddr, sub_idx, last,
    output addr_ready
  );
endinterface

// File: rtl/operand_addr_seq_addr_chan_ctr.sv
// One channel's read address: a counter wrapping at DEPTH-1, with clear taking
// priority over increment.
module addr_chan_ctr #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/operand_addr_seq.sv
// Operand-buffer read-address sequencer: issues len_eff words per run on NUM_CH
// lockstep channels, repeating each word once per sub-word lane of the precision.
module operand_addr_seq
  import operand_addr_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  prec_e                 prec,
  input  logic [LEN_W-1:0]      len,
  input  logic [NUM_CH-1:0]     restart,
  input  logic                  abort,
  operand_addr_seq_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output aseq_state_e           state
);

  localparam int               CNT_W   = LEN_W + 3;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic [2:0]        rep_m1;
  logic [2:0]        sub_q;
  logic [CNT_W-1:0]  beat_q;
  logic [CNT_W-1:0]  total_m1;
  logic [NUM_CH-1:0] pend_q;
  logic [LEN_W-1:0]  len_eff;
  logic [CNT_W-1:0]  total_in;
  logic              accept;
  logic              is_last;
  logic              word_end;
  logic [ADDR_W-1:0] ch_addr [NUM_CH];

  assign len_eff  = (len > DEPTH_L) ? DEPTH_L : len;
  assign total_in = CNT_W'(len_eff) * CNT_W'(rep_of(prec));

  // abort wins over a beat presented in the same cycle, so nothing advances.
  assign accept   = (state == RUN) && bus.addr_ready && !abort;
  assign is_last  = (state == RUN) && (beat_q == total_m1);
  assign word_end = (sub_q == rep_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rep_m1   <= '0;
      total_m1 <= '0;
      sub_q    <= '0;
      beat_q   <= '0;
      pend_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          sub_q  <= '0;
          beat_q <= '0;
          pend_q <= '0;
          if (start && !abort) begin
            rep_m1   <= 3'(rep_of(prec) - 4'd1);
            total_m1 <= total_in - CNT_W'(1);
            state    <= (len_eff == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state  <= IDLE;
            sub_q  <= '0;
            beat_q <= '0;
            pend_q <= '0;
          end else if (accept) begin
            beat_q <= beat_q + CNT_W'(1);
            sub_q  <= word_end ? 3'd0 : sub_q + 3'd1;
            pend_q <= '0;
            if (is_last) state <= DONE;
          end else begin
            // A restart seen during a stall is held until the beat is taken.
            pend_q <= pend_q | restart;
          end
        end
        DONE: begin
          state  <= IDLE;
          sub_q  <= '0;
          beat_q <= '0;
          pend_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses sit at 0 outside RUN and are cleared on the final beat so the
  // first beat of every run starts from word 0.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic clr_c;
    logic inc_c;

    assign clr_c = (state != RUN) || abort ||
                   (accept && (restart[c] || pend_q[c] || is_last));
    assign inc_c = accept && word_end;

    addr_chan_ctr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_c),
      .clr  (clr_c),
      .addr (ch_addr[c])
    );
  end

  always_comb begin
    bus.rdaddr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.rdaddr[c*ADDR_W +: ADDR_W] = ch_addr[c];
    end
  end

  assign bus.addr_valid = (state == RUN);
  assign bus.sub_idx    = sub_q;
  assign bus.last       = is_last;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_operand_addr_seq.sv
// Bench for operand_addr_seq: directed runs against a beat-list model built from
// word/lane arithmetic, checked beat by beat by a negedge monitor.
module tb_operand_addr_seq;
  import operand_addr_seq_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 2;
  localparam int LEN_W  = 5;
  localparam int EW     = NUM_CH*ADDR_W + 4;
  localparam int LIMIT  = 400;

  logic              clk;
  logic              rst;
  logic              start;
  prec_e             prec;
  logic [LEN_W-1:0]  len;
  logic [NUM_CH-1:0] restart;
  logic              abort;
  logic              busy;
  logic              done;
  aseq_state_e       state_dbg;

  operand_addr_seq_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

  operand_addr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .prec    (prec),
    .len     (len),
    .restart (restart),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .state   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  time t_last  = 0;
  time t_done  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat k of a run reads word k/REP in lane k%REP; a channel restarted on
  // beat rb (1-based) counts words again from the beat after it.
  task automatic plan(input int p, input int ln, input int rb, input logic [NUM_CH-1:0] rm);
    int rep;
    int le;
    int tot;
    rep = 1 << p;
    le  = (ln > DEPTH) ? DEPTH : ln;
    tot = le * rep;
    exp_q.delete();
    for (int k = 0; k < tot; k++) begin
      logic [EW-1:0] e;
      e = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        int a;
        if (rm[c] && rb > 0 && k >= rb) a = (k/rep - rb/rep) % DEPTH;
        else                            a = (k/rep) % DEPTH;
        e[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
      end
      e[NUM_CH*ADDR_W +: 3] = 3'(k % rep);
      e[EW-1] = (k == tot - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_v = 1'b0;
  logic [EW:0]   held;
  logic          prev_done = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] word;
    logic [EW-1:0] e;
    if (rst) begin
      hold_v    = 1'b0;
      prev_done = 1'b0;
    end else begin
      word = {bus.last, bus.sub_idx, bus.rdaddr};
      if (hold_v) chk("stall_hold", 32'({bus.addr_valid, word}), 32'(held));
      if (prev_done) chk("idle_after_done", 32'(busy), 32'd0);
      if (bus.addr_valid && bus.addr_ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'({1'b1, word}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'(word), 32'(e));
        end
        acc_cnt++;
        if (bus.last) t_last = $time;
      end
      hold_v = bus.addr_valid && !bus.addr_ready && !abort;
      held   = {bus.addr_valid, word};
      if (done) begin
        done_cnt++;
        t_done = $time;
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic run_case(input string nm, input int p, input int ln,
                          input int stall_a, input int stall_b,
                          input int rb, input logic [NUM_CH-1:0] rm);
    int tot;
    int beat;
    int stalled;
    int cyc;
    logic acc;
    tot      = exp_q.size();
    done_cnt = 0;
    acc_cnt  = 0;
    @(posedge clk); #1;
    start = 1'b1;
    prec  = prec_e'(2'(p));
    len   = LEN_W'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_first_valid"}, 32'(bus.addr_valid), 32'(tot > 0));
    if (tot > 0) chk({nm, "_first_addr"}, 32'({bus.sub_idx, bus.rdaddr}), 32'd0);
    beat    = 1;
    stalled = 0;
    cyc     = 0;
    while (busy && cyc < LIMIT) begin
      if ((beat == stall_a || beat == stall_b) && stalled != beat) begin
        bus.addr_ready = 1'b0;
        stalled = beat;
      end else begin
        bus.addr_ready = 1'b1;
      end
      restart = (beat == rb) ? rm : '0;
      acc = bus.addr_valid && bus.addr_ready;
      @(posedge clk); #1;
      if (acc) beat++;
      cyc++;
    end
    bus.addr_ready = 1'b1;
    restart = '0;
    chk({nm, "_timeout"}, 32'(cyc < LIMIT), 32'd1);
    chk({nm, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_beat_count"}, 32'(acc_cnt), 32'(tot));
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (tot > 0) chk({nm, "_done_latency"}, 32'(t_done - t_last), 32'd10);
  endtask

  task automatic start_and_reach_beat3(input int p, input int ln);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    prec  = prec_e'(2'(p));
    len   = LEN_W'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    prec           = PREC_FP32;
    len            = '0;
    restart        = '0;
    abort          = 1'b0;
    bus.addr_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_rdaddr", 32'(bus.rdaddr), 32'd0);
    chk("rst_sub_idx", 32'(bus.sub_idx), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    plan(0, 4, 0, '0);
    chk("model_fp32_last", 32'(exp_q[3]), 32'h833);
    run_case("fp32_len4", 0, 4, 0, 0, 0, '0);

    plan(3, 2, 0, '0);
    chk("model_int4_b9", 32'(exp_q[8]), 32'h011);
    chk("model_int4_last", 32'(exp_q[15]), 32'hF11);
    run_case("int4_len2", 3, 2, 0, 0, 0, '0);

    plan(1, 3, 0, '0);
    chk("model_fp16_b4", 32'(exp_q[3]), 32'h111);
    run_case("fp16_stall", 1, 3, 2, 5, 0, '0);

    plan(2, 4, 6, 2'b10);
    chk("model_int8_b7", 32'(exp_q[6]), 32'h201);
    chk("model_int8_last", 32'(exp_q[15]), 32'hB23);
    run_case("int8_restart", 2, 4, 0, 0, 6, 2'b10);

    plan(0, 0, 0, '0);
    run_case("len0", 0, 0, 0, 0, 0, '0);

    plan(0, 20, 0, '0);
    chk("model_clamp_size", 32'(exp_q.size()), 32'd16);
    chk("model_clamp_last", 32'(exp_q[15]), 32'h8FF);
    run_case("len20_clamp", 0, 20, 0, 0, 0, '0);

    // Reset lands while beat 3 is presented.
    plan(0, 8, 0, '0);
    start_and_reach_beat3(0, 8);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.addr_valid), 32'd0);
    chk("midrst_rdaddr", 32'(bus.rdaddr), 32'd0);
    chk("midrst_sub_idx", 32'(bus.sub_idx), 32'd0);
    chk("midrst_last", 32'(bus.last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_beats_taken", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    plan(0, 3, 0, '0);
    run_case("after_rst", 0, 3, 0, 0, 0, '0);

    // Abort while beat 3 is presented: that beat is not taken.
    plan(1, 4, 0, '0);
    start_and_reach_beat3(1, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bus.addr_valid), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    chk("abort_beats_left", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    plan(2, 1, 0, '0);
    run_case("after_abort", 2, 1, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
